// File: rtl/u712_chipram_arbiter.sv
// Chip RAM SDRAM arbiter: grants one of Agnus DMA, CPU or auto-refresh at a time,
// enforces a precharge gap after each cycle and owns the refresh interval timer.
module u712_chipram_arbiter #(
  parameter int REF_PERIOD   = 600,
  parameter int REF_DEBT_MAX = 3,
  parameter int GAP_CYCLES   = 2
) (
  input  logic       i_clk80,
  input  logic       i_reset,
  input  logic       i_dma_req,
  input  logic       i_dma_pending,
  input  logic       i_cpu_req,
  input  logic       i_cpu_burst,
  input  logic       i_cycle_done,
  output logic       o_gnt_dma,
  output logic       o_gnt_cpu,
  output logic       o_gnt_ref,
  output logic       o_start,
  output logic       o_cpu_ack,
  output logic       o_burst_ok,
  output logic [1:0] o_ref_debt,
  output logic       o_ref_overrun,
  output logic       o_busy
);

  localparam int CNT_W = $clog2(REF_PERIOD);
  localparam int GAP_W = 3;
  localparam logic [1:0] DEBT_MAX = 2'(REF_DEBT_MAX);

  typedef enum logic [2:0] {S_IDLE, S_DMA, S_CPU, S_REF, S_GAP} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [GAP_W-1:0]   w_gap_cnt_next;
  logic [CNT_W-1:0]   r_ref_cnt;
  logic [1:0]         r_ref_debt;
  logic               r_ref_overrun;
  logic               r_gnt_dma;
  logic               r_gnt_cpu;
  logic               r_gnt_ref;
  logic               r_start;
  logic               r_cpu_ack;
  logic               r_burst_ok;
  logic               r_busy;
  logic               w_tick;
  logic               w_grant;
  logic               w_ref_start;

  always_comb begin
    w_state_next   = r_state;
    w_gap_cnt_next = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        // Urgent refresh outranks CPU and ignores DMA_PENDING; only a real DMA beats it
        if (i_dma_req)                                      w_state_next = S_DMA;
        else if (r_ref_debt == DEBT_MAX)                    w_state_next = S_REF;
        else if (i_cpu_req && !i_dma_pending)               w_state_next = S_CPU;
        else if (r_ref_debt != 2'd0 && !i_dma_pending && !i_cpu_req)
                                                            w_state_next = S_REF;
      end
      S_DMA, S_CPU, S_REF: begin
        if (i_cycle_done) begin
          w_state_next   = S_GAP;
          w_gap_cnt_next = GAP_W'(GAP_CYCLES - 1);
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) w_state_next   = S_IDLE;
        else                 w_gap_cnt_next = r_gap_cnt - GAP_W'(1);
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_grant     = (r_state == S_IDLE) && (w_state_next != S_IDLE);
  assign w_ref_start = (r_state == S_IDLE) && (w_state_next == S_REF);
  assign w_tick      = (r_ref_cnt == CNT_W'(REF_PERIOD - 1));

  always_ff @(posedge i_clk80) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_gap_cnt     <= '0;
      r_ref_cnt     <= '0;
      r_ref_debt    <= 2'd0;
      r_ref_overrun <= 1'b0;
      r_gnt_dma     <= 1'b0;
      r_gnt_cpu     <= 1'b0;
      r_gnt_ref     <= 1'b0;
      r_start       <= 1'b0;
      r_cpu_ack     <= 1'b0;
      r_burst_ok    <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_gap_cnt <= w_gap_cnt_next;
      r_ref_cnt <= w_tick ? '0 : r_ref_cnt + CNT_W'(1);

      if (w_tick && r_ref_debt == DEBT_MAX) r_ref_overrun <= 1'b1;
      // A tick coinciding with a refresh start cancels out
      if (w_tick && !w_ref_start && r_ref_debt != DEBT_MAX)
        r_ref_debt <= r_ref_debt + 2'd1;
      else if (!w_tick && w_ref_start)
        r_ref_debt <= r_ref_debt - 2'd1;

      r_gnt_dma <= (w_state_next == S_DMA);
      r_gnt_cpu <= (w_state_next == S_CPU);
      r_gnt_ref <= (w_state_next == S_REF);
      r_start   <= w_grant;
      r_cpu_ack <= w_grant && (w_state_next == S_CPU);
      r_busy    <= (w_state_next != S_IDLE);

      // Once DMA is imminent the burst is cut short for the rest of this grant
      if (w_grant && w_state_next == S_CPU)
        r_burst_ok <= i_cpu_burst && !i_dma_pending;
      else if (w_state_next != S_CPU || i_dma_pending)
        r_burst_ok <= 1'b0;
    end
  end

  assign o_gnt_dma     = r_gnt_dma;
  assign o_gnt_cpu     = r_gnt_cpu;
  assign o_gnt_ref     = r_gnt_ref;
  assign o_start       = r_start;
  assign o_cpu_ack     = r_cpu_ack;
  assign o_burst_ok    = r_burst_ok;
  assign o_ref_debt    = r_ref_debt;
  assign o_ref_overrun = r_ref_overrun;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_u712_chipram_arbiter.sv
// Bench for u712_chipram_arbiter: directed vector table, hand-written refresh/reset
// sequences and randomized traffic, all checked cycle by cycle against a reference model.
`timescale 1ns/1ps
module tb_u712_chipram_arbiter;

  localparam int REF_PERIOD = 600;
  localparam int DEBT_MAX   = 3;
  localparam int GAP        = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dma_req = 1'b0, dpend = 1'b0, cpu_req = 1'b0, cpu_burst = 1'b0, done = 1'b0;
  logic gnt_dma, gnt_cpu, gnt_ref, start, ack, burst, ovr, busy;
  logic [1:0] debt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner 0=none 1=dma 2=cpu 3=ref; m_gap = gap cycles still to run
  int m_owner, m_gap, m_cyc, m_debt;
  bit m_ovr, m_start, m_ack, m_burst;

  u712_chipram_arbiter #(.REF_PERIOD(REF_PERIOD), .REF_DEBT_MAX(DEBT_MAX), .GAP_CYCLES(GAP)) dut (
    .i_clk80(clk), .i_reset(rst), .i_dma_req(dma_req), .i_dma_pending(dpend),
    .i_cpu_req(cpu_req), .i_cpu_burst(cpu_burst), .i_cycle_done(done),
    .o_gnt_dma(gnt_dma), .o_gnt_cpu(gnt_cpu), .o_gnt_ref(gnt_ref), .o_start(start),
    .o_cpu_ack(ack), .o_burst_ok(burst), .o_ref_debt(debt), .o_ref_overrun(ovr), .o_busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1, "timeout");
  end

  task automatic model_edge();
    bit tick, dec;
    if (rst) begin
      m_owner = 0; m_gap = 0; m_cyc = 0; m_debt = 0;
      m_ovr = 0; m_start = 0; m_ack = 0; m_burst = 0;
      return;
    end
    m_cyc++;
    tick = (m_cyc % REF_PERIOD) == 0;
    m_start = 0; m_ack = 0; dec = 0;
    if (m_owner != 0) begin
      if (done) begin m_owner = 0; m_gap = GAP; m_burst = 0; end
      else if (m_owner == 2 && dpend) m_burst = 0;
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      if (dma_req) m_owner = 1;
      else if (m_debt == DEBT_MAX) m_owner = 3;
      else if (cpu_req && !dpend) begin m_owner = 2; m_ack = 1; m_burst = cpu_burst; end
      else if (m_debt > 0 && !dpend && !cpu_req) m_owner = 3;
      m_start = (m_owner != 0);
      dec = (m_owner == 3);
    end
    if (tick && m_debt == DEBT_MAX) m_ovr = 1;
    m_debt = m_debt + (tick ? 1 : 0) - (dec ? 1 : 0);
    if (m_debt > DEBT_MAX) m_debt = DEBT_MAX;
  endtask

  function automatic logic [9:0] dut_vec();
    return {gnt_dma, gnt_cpu, gnt_ref, start, ack, burst, debt, ovr, busy};
  endfunction

  function automatic logic [9:0] model_vec();
    return {m_owner == 1, m_owner == 2, m_owner == 3, m_start, m_ack, m_burst,
            2'(m_debt), m_ovr, (m_owner != 0) || (m_gap > 0)};
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check($sformatf("model cyc%0d", m_cyc), dut_vec(), model_vec());
  endtask

  task automatic do_reset();
    rst = 1; dma_req = 0; dpend = 0; cpu_req = 0; cpu_burst = 0; done = 0;
    step(); step();
    rst = 0;
  endtask

  typedef struct {
    logic dma, dp, cpu, cb, dn;
    logic [2:0] gnt;
    logic st, ak, bo, bz;
  } vec_t;

  function automatic vec_t mk(logic dma, logic dp, logic cpu, logic cb, logic dn,
                              logic [2:0] gnt, logic st, logic ak, logic bo, logic bz);
    vec_t v;
    v.dma = dma; v.dp = dp; v.cpu = cpu; v.cb = cb; v.dn = dn;
    v.gnt = gnt; v.st = st; v.ak = ak; v.bo = bo; v.bz = bz;
    return v;
  endfunction

  vec_t tbl [15];
  int   cnt;

  initial begin
    //           dma dp cpu cb dn   gnt{d,c,r} st ak bo bz
    tbl[0]  = mk(0, 0, 1, 1, 0,   3'b010,    1, 1, 1, 1);  // CPU burst grant
    tbl[1]  = mk(0, 0, 0, 0, 0,   3'b010,    0, 0, 1, 1);
    tbl[2]  = mk(0, 0, 0, 0, 0,   3'b010,    0, 0, 1, 1);
    tbl[3]  = mk(0, 1, 0, 0, 0,   3'b010,    0, 0, 0, 1);  // DMA_PENDING kills burst
    tbl[4]  = mk(0, 0, 0, 0, 0,   3'b010,    0, 0, 0, 1);  // stays killed
    tbl[5]  = mk(0, 0, 0, 0, 1,   3'b000,    0, 0, 0, 1);  // done -> gap 1
    tbl[6]  = mk(1, 0, 1, 0, 0,   3'b000,    0, 0, 0, 1);  // gap 2
    tbl[7]  = mk(1, 0, 1, 0, 0,   3'b000,    0, 0, 0, 0);  // idle
    tbl[8]  = mk(1, 0, 1, 0, 0,   3'b100,    1, 0, 0, 1);  // DMA beats CPU
    tbl[9]  = mk(0, 0, 1, 0, 0,   3'b100,    0, 0, 0, 1);
    tbl[10] = mk(0, 0, 1, 0, 1,   3'b000,    0, 0, 0, 1);
    tbl[11] = mk(0, 0, 1, 0, 0,   3'b000,    0, 0, 0, 1);
    tbl[12] = mk(0, 0, 1, 0, 0,   3'b000,    0, 0, 0, 0);
    tbl[13] = mk(0, 0, 1, 0, 0,   3'b010,    1, 1, 0, 1);  // 4th cycle after done
    tbl[14] = mk(0, 0, 0, 0, 1,   3'b000,    0, 0, 0, 1);

    do_reset();
    check("reset_state", dut_vec(), 10'b0);
    for (int i = 0; i < 15; i++) begin
      dma_req = tbl[i].dma; dpend = tbl[i].dp; cpu_req = tbl[i].cpu;
      cpu_burst = tbl[i].cb; done = tbl[i].dn;
      step();
      check($sformatf("tbl[%0d]", i), {3'b0, gnt_dma, gnt_cpu, gnt_ref, start, ack, burst, busy},
            {3'b0, tbl[i].gnt, tbl[i].st, tbl[i].ak, tbl[i].bo, tbl[i].bz});
    end

    // First refresh tick and its grant
    do_reset();
    repeat (REF_PERIOD - 1) step();
    check("a_debt_before_tick", {8'b0, debt}, 10'd0);
    step();
    check("a_debt_at_tick", {8'b0, debt}, 10'd1);
    step();
    check("a_ref_grant", {7'b0, gnt_ref, start, debt == 2'd0}, 10'b111);
    done = 1; step(); done = 0;
    check("a_ref_drop", {9'b0, gnt_ref}, 10'd0);

    // Urgent refresh while DMA_PENDING blocks CPU and optional refresh
    do_reset();
    dpend = 1; cpu_req = 1; cnt = 0;
    for (int i = 1; i <= 3 * REF_PERIOD; i++) begin
      step();
      if (gnt_cpu || gnt_ref) cnt++;
    end
    check("b_no_early_grant", 10'(cnt), 10'd0);
    check("b_debt_full", {8'b0, debt}, 10'd3);
    step();
    check("b_urgent_ref", {7'b0, gnt_ref, gnt_cpu, start}, 10'b101);
    done = 1; step(); done = 0; dpend = 0; cpu_req = 0;
    repeat (4) step();

    // Continuous DMA starves refresh until overrun
    do_reset();
    dma_req = 1; cnt = 0;
    for (int i = 1; i <= 2500; i++) begin
      step();
      if (gnt_ref) cnt++;
      done = gnt_dma && !done;
      if (i == 4 * REF_PERIOD - 1) check("c_no_overrun_yet", {9'b0, ovr}, 10'd0);
      if (i == 4 * REF_PERIOD)     check("c_overrun_set", {9'b0, ovr}, 10'd1);
    end
    check("c_debt_sat", {8'b0, debt}, 10'd3);
    check("c_no_ref_grant", 10'(cnt), 10'd0);
    dma_req = 0; done = 0;
    repeat (4) step();

    // Reset in the middle of a CPU grant with refresh debt outstanding
    do_reset();
    dpend = 1;
    repeat (2 * REF_PERIOD) step();
    check("d_debt2", {8'b0, debt}, 10'd2);
    dpend = 0; cpu_req = 1;
    step();
    check("d_cpu_grant", {7'b0, gnt_cpu, debt}, 10'b110);
    cpu_req = 0;
    step();
    rst = 1;
    step();
    check("d_reset_mid_grant", dut_vec(), 10'b0);
    rst = 0;

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) dpend = ~dpend;
      if (!dma_req && $urandom_range(0, 15) == 0) dma_req = 1;
      if (!cpu_req && $urandom_range(0, 5) == 0) cpu_req = 1;
      cpu_burst = 1'($urandom_range(0, 1));
      if (m_owner != 0 && !m_start) done = ($urandom_range(0, 2) == 0);
      else                          done = ($urandom_range(0, 15) == 0);
      step();
      if (m_start && m_owner == 1) dma_req = 0;
      if (m_ack) cpu_req = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
